// File: rtl/bridge_pkg.sv
// Grayscale mode encoding shared with the video bridge.
package bridge_pkg;
    localparam logic grayscale_supported = 1'b1;
    localparam logic grayscale_off       = 1'b0;
endpackage

// File: rtl/display_mode_pkg.sv
// State encoding for the display mode sequencer.
package display_mode_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        DONE    = 2'd2
    } display_mode_seq_state_e;
endpackage

// File: rtl/display_mode_sequencer_vs_edge_detect.sv
// Registered rising-edge detector for the video vertical sync.
module vs_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);
    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig_in & ~sig_q;
endmodule

// File: rtl/display_mode_sequencer.sv
// Applies host grayscale requests at the next vertical sync rising edge.
// Define DISPLAY_MODE_SEQUENCER_TIMEOUT_EN to force the apply after TIMEOUT_CYCLES without vsync.
module display_mode_sequencer
    import display_mode_pkg::*;
#(
    parameter logic        supports_grayscale = 1'b0,
    parameter logic [31:0] TIMEOUT_CYCLES     = 32'd2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_grayscale,
    output logic req_ready,
    output logic req_done,
    output logic affirm_grayscale,
    input  logic video_vs,
    output logic grayscale_active,
    output logic busy,
    output logic timed_out
);
    display_mode_seq_state_e state_q, state_d;
    logic target_q, target_d;
    logic gray_q, gray_d;
    logic done_q, done_d;
    logic vs_rise;
    logic accept_target;
    logic timeout_hit;

    vs_edge_detect u_vs_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (video_vs),
        .rise   (vs_rise)
    );

`ifdef DISPLAY_MODE_SEQUENCER_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic timed_q, timed_d;

    assign timeout_hit = (cnt_q == TIMEOUT_CYCLES - 32'd1);
    assign timed_out   = timed_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
    assign timed_out             = 1'b0;
`endif

    assign accept_target    = (req_grayscale == bridge_pkg::grayscale_supported) && supports_grayscale;
    assign req_ready        = (state_q == IDLE) && !reset;
    assign req_done         = done_q;
    assign busy             = (state_q != IDLE);
    assign grayscale_active = gray_q;
    assign affirm_grayscale = gray_q;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        gray_d   = gray_q;
        done_d   = 1'b0;
`ifdef DISPLAY_MODE_SEQUENCER_TIMEOUT_EN
        cnt_d    = cnt_q;
        timed_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    target_d = accept_target;
`ifdef DISPLAY_MODE_SEQUENCER_TIMEOUT_EN
                    cnt_d    = 32'd0;
`endif
                    // Nothing to switch: complete without waiting for a frame.
                    if (accept_target == gray_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_VS;
                    end
                end
            end
            WAIT_VS: begin
`ifdef DISPLAY_MODE_SEQUENCER_TIMEOUT_EN
                cnt_d = cnt_q + 32'd1;
`endif
                if (vs_rise || timeout_hit) begin
                    gray_d  = target_q;
                    state_d = DONE;
                    done_d  = 1'b1;
`ifdef DISPLAY_MODE_SEQUENCER_TIMEOUT_EN
                    // A real edge on the deadline cycle counts as a normal apply.
                    timed_d = !vs_rise;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= 1'b0;
            gray_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DISPLAY_MODE_SEQUENCER_TIMEOUT_EN
            cnt_q    <= 32'd0;
            timed_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            gray_q   <= gray_d;
            done_q   <= done_d;
`ifdef DISPLAY_MODE_SEQUENCER_TIMEOUT_EN
            cnt_q    <= cnt_d;
            timed_q  <= timed_d;
`endif
        end
    end
endmodule
